// File: rtl/chacha_pkg.sv
// Shared constants, widths and controller state encoding for the ChaCha
// keystream controller and its block core.
package chacha_pkg;

    localparam int BLOCK_W = 512;

    // "expand 32-byte k" as four little-endian words
    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// Command and keystream bus between a host and chacha_stream_ctrl, plus a
// read-only view of the controller state for observation.
interface chacha_stream_ctrl_if;
    import chacha_pkg::*;

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; the sender holds valid and payload steady until
    // then, and ready may not depend on valid.
    logic               cmd_valid;
    logic               cmd_ready;
    logic [255:0]       key;
    logic [95:0]        nonce;
    logic [31:0]        ctr_init;
    logic [15:0]        num_blocks;
    logic               abort;
    logic               ks_valid;
    logic               ks_ready;
    logic [BLOCK_W-1:0] ks_data;
    logic               ks_last;
    logic               busy;
    logic               done;
    state_t             dbg_state;

    modport master (
        output cmd_valid, key, nonce, ctr_init, num_blocks, abort, ks_ready,
        input  cmd_ready, ks_valid, ks_data, ks_last, busy, done, dbg_state
    );

    modport slave (
        input  cmd_valid, key, nonce, ctr_init, num_blocks, abort, ks_ready,
        output cmd_ready, ks_valid, ks_data, ks_last, busy, done, dbg_state
    );

endinterface

// File: rtl/chacha_block.sv
// Iterative ChaCha block function: one round per clock, then the final
// feed-forward add. Result is held on o_state until the next completion.
module chacha_block
    import chacha_pkg::*;
#(
    parameter int NUM_ROUNDS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [BLOCK_W-1:0] i_state,
    output logic [BLOCK_W-1:0] o_state,
    output logic               o_done
);

    localparam int RW = $clog2(NUM_ROUNDS + 1);

    logic [31:0]        r_x [16];
    logic [BLOCK_W-1:0] r_in;
    logic [BLOCK_W-1:0] r_out;
    logic [RW-1:0]      r_rnd;
    logic               r_run;
    logic               r_done;

    logic [31:0]        w_x [16];
    logic [BLOCK_W-1:0] w_sum;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Even round index = column round, odd = diagonal round
    always_comb begin
        for (int i = 0; i < 16; i++) w_x[i] = r_x[i];
        for (int i = 0; i < 4; i++) begin
            if (!r_rnd[0]) begin
                {w_x[i], w_x[4+i], w_x[8+i], w_x[12+i]} =
                    qr(r_x[i], r_x[4+i], r_x[8+i], r_x[12+i]);
            end else begin
                {w_x[i], w_x[4+((i+1)%4)], w_x[8+((i+2)%4)], w_x[12+((i+3)%4)]} =
                    qr(r_x[i], r_x[4+((i+1)%4)], r_x[8+((i+2)%4)], r_x[12+((i+3)%4)]);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 16; i++) begin
            w_sum[BLOCK_W-1-32*i -: 32] = r_x[i] + r_in[BLOCK_W-1-32*i -: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_x[i] <= '0;
            r_in   <= '0;
            r_out  <= '0;
            r_rnd  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                for (int i = 0; i < 16; i++) r_x[i] <= i_state[BLOCK_W-1-32*i -: 32];
                r_in  <= i_state;
                r_rnd <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                if (r_rnd == RW'(NUM_ROUNDS)) begin
                    r_out  <= w_sum;
                    r_done <= 1'b1;
                    r_run  <= 1'b0;
                end else begin
                    for (int i = 0; i < 16; i++) r_x[i] <= w_x[i];
                    r_rnd <= r_rnd + RW'(1);
                end
            end
        end
    end

    assign o_state = r_out;
    assign o_done  = r_done;

endmodule

// File: rtl/chacha_stream_ctrl.sv
// Keystream controller: accepts a command, runs the block core once per
// block with an incrementing counter, and hands out 512-bit blocks.
module chacha_stream_ctrl
    import chacha_pkg::*;
#(
    parameter int NUM_ROUNDS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chacha_stream_ctrl_if.slave  bus
);

    state_t             r_state;
    state_t             w_next;
    logic               r_live;
    logic               r_done;
    logic [255:0]       r_key;
    logic [95:0]        r_nonce;
    logic [31:0]        r_ctr;
    logic [15:0]        r_rem;

    logic               w_cmd_hs;
    logic               w_latch;
    logic               w_adv;
    logic               w_done_set;
    logic               w_core_start;
    logic               w_core_done;
    logic [BLOCK_W-1:0] w_state_in;
    logic [BLOCK_W-1:0] w_core_out;

    assign w_state_in = {SIGMA0, SIGMA1, SIGMA2, SIGMA3, r_key, r_ctr, r_nonce};

    chacha_block #(
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_core_start),
        .i_state (w_state_in),
        .o_state (w_core_out),
        .o_done  (w_core_done)
    );

    // r_live keeps cmd_ready low until the first edge after reset release
    assign w_cmd_hs = bus.cmd_valid && r_live && (r_state == ST_IDLE);

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_adv        = 1'b0;
        w_done_set   = 1'b0;
        w_core_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_latch = 1'b1;
                    if (bus.num_blocks == '0) w_done_set = 1'b1;
                    else                      w_next     = ST_START;
                end
            end
            ST_START: begin
                w_core_start = 1'b1;
                w_next       = bus.abort ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                // An abort coinciding with core done has nothing left to drain
                if (bus.abort) begin
                    if (w_core_done) begin
                        w_done_set = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_next = ST_DRAIN;
                    end
                end else if (w_core_done) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.abort) begin
                    w_done_set = 1'b1;
                    w_next     = ST_IDLE;
                end else if (bus.ks_ready) begin
                    if (r_rem == 16'd1) begin
                        w_done_set = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = ST_START;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_core_done) begin
                    w_done_set = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_done  <= 1'b0;
            r_key   <= '0;
            r_nonce <= '0;
            r_ctr   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            r_done  <= w_done_set;
            if (w_latch) begin
                r_key   <= bus.key;
                r_nonce <= bus.nonce;
                r_ctr   <= bus.ctr_init;
                r_rem   <= bus.num_blocks;
            end else if (w_adv) begin
                r_ctr <= r_ctr + 32'd1;
                r_rem <= r_rem - 16'd1;
            end
        end
    end

    assign bus.cmd_ready = r_live && (r_state == ST_IDLE);
    assign bus.ks_valid  = (r_state == ST_OUT);
    assign bus.ks_last   = (r_state == ST_OUT) && (r_rem == 16'd1);
    assign bus.ks_data   = w_core_out;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule
